// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage MIPS pipeline: pipeline register
// write/flush controls, a mult/div busy FSM and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6,
    parameter int PERF_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_MemRead,
    input  logic [4:0]        ex_rt_rd,
    input  logic              ex_muldiv,
    input  logic              mem_branch,
    input  logic              mem_bne,
    input  logic              mem_zero,
    input  logic              mem_jump,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_write,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              muldiv_busy,
    output logic [PERF_W-1:0] stall_cnt
);

    typedef enum logic {RUN, MD_BUSY} state_t;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] md_cnt, md_cnt_nxt;
    logic             mem_taken;
    logic             load_use;

    assign mem_taken = (mem_branch & mem_zero) | (mem_bne & ~mem_zero) | mem_jump;
    assign load_use  = ex_MemRead & (ex_rt_rd != 5'd0) &
                       ((ex_rt_rd == id_rs) | (id_uses_rt & (ex_rt_rd == id_rt)));

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path can infer a latch.
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        muldiv_busy = rst && (state == MD_BUSY);
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;

        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_taken) begin
            // Wrong-path work is squashed everywhere, including any mult/div in EX.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_nxt   = RUN;
        end else if (state == RUN) begin
            if (ex_muldiv) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_flush = 1'b1;
                md_cnt_nxt  = MD_LOAD;
                state_nxt   = MD_BUSY;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end else if (md_cnt != '0) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
            md_cnt_nxt  = md_cnt - CNT_W'(1);
        end else begin
            // Release cycle: the pipeline advances; load_use and ex_muldiv are not looked at.
            state_nxt = RUN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            md_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (!pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table vectors, directed multi-cycle
// sequences and random stimulus against a cycle-level reference model.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] rt_rd;
        logic       muldiv;
        logic       branch;
        logic       bne;
        logic       zero;
        logic       jump;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic [6:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt_rd = '0;
    logic       id_uses_rt = 1'b0, ex_MemRead = 1'b0, ex_muldiv = 1'b0;
    logic       mem_branch = 1'b0, mem_bne = 1'b0, mem_zero = 1'b0, mem_jump = 1'b0;

    logic        pc0, ifw0, idw0, iff0, idf0, exf0, busy0;
    logic        pc1, ifw1, idw1, iff1, idf1, exf1, busy1;
    logic [3:0]  cnt0;
    logic [15:0] cnt1;

    hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(6), .PERF_W(4)) dut0 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_rt_rd(ex_rt_rd), .ex_muldiv(ex_muldiv),
        .mem_branch(mem_branch), .mem_bne(mem_bne), .mem_zero(mem_zero), .mem_jump(mem_jump),
        .pc_write(pc0), .ifid_write(ifw0), .idex_write(idw0), .ifid_flush(iff0),
        .idex_flush(idf0), .exmem_flush(exf0), .muldiv_busy(busy0), .stall_cnt(cnt0));

    hazard_ctrl #(.MULDIV_CYCLES(1), .CNT_W(2), .PERF_W(16)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_rt_rd(ex_rt_rd), .ex_muldiv(ex_muldiv),
        .mem_branch(mem_branch), .mem_bne(mem_bne), .mem_zero(mem_zero), .mem_jump(mem_jump),
        .pc_write(pc1), .ifid_write(ifw1), .idex_write(idw1), .ifid_flush(iff1),
        .idex_flush(idf1), .exmem_flush(exf1), .muldiv_busy(busy1), .stall_cnt(cnt1));

    wire [6:0] o0 = {pc0, ifw0, idw0, iff0, idf0, exf0, busy0};
    wire [6:0] o1 = {pc1, ifw1, idw1, iff1, idf1, exf1, busy1};

    int checks = 0;
    int errors = 0;

    // Model state per instance: MD_BUSY cycles still to run (0 = running) and stall count.
    int m_busy [2] = '{0, 0};
    int m_cnt  [2] = '{0, 0};
    int m_n    [2] = '{4, 1};
    int m_max  [2] = '{15, 65535};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic bit taken_f(input stim_t s);
        return (s.branch && s.zero) || (s.bne && !s.zero) || s.jump;
    endfunction

    function automatic bit lu_f(input stim_t s);
        return s.memread && s.rt_rd != 0 && (s.rt_rd == s.rs || (s.uses_rt && s.rt_rd == s.rt));
    endfunction

    // Bits: pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, muldiv_busy.
    function automatic logic [6:0] model_out(input stim_t s, input int busy);
        if (!s.rst)                 return 7'b0001110;
        if (taken_f(s))             return {6'b111111, busy > 0};
        if (busy > 1)               return 7'b0000011;
        if (busy == 1)              return 7'b1110001;
        if (s.muldiv)               return 7'b0000010;
        if (lu_f(s))                return 7'b0010100;
        return 7'b1110000;
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.uses_rt;
        ex_MemRead = s.memread; ex_rt_rd = s.rt_rd; ex_muldiv = s.muldiv;
        mem_branch = s.branch; mem_bne = s.bne; mem_zero = s.zero; mem_jump = s.jump;
    endtask

    task automatic step(input stim_t s, input string name, input bit has_tab,
                        input logic [6:0] tab, output logic [6:0] seen);
        logic [6:0] exp [2];
        @(negedge clk);
        apply(s);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp[i] = model_out(s, m_busy[i]);
            check($sformatf("%s_outs%0d", name, i), 32'(i == 0 ? o0 : o1), 32'(exp[i]));
            check($sformatf("%s_cnt%0d", name, i), (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'(m_cnt[i]));
        end
        if (has_tab) check($sformatf("%s_tab", name), 32'(o0), 32'(tab));
        seen = o0;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!s.rst) begin
                m_busy[i] = 0;
                m_cnt[i]  = 0;
            end else begin
                if (!exp[i][6] && m_cnt[i] < m_max[i]) m_cnt[i]++;
                if (taken_f(s))       m_busy[i] = 0;
                else if (m_busy[i] > 0) m_busy[i]--;
                else if (s.muldiv)    m_busy[i] = m_n[i];
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        stim_t s = idle();
        logic [6:0] seen;
        s.rst = 1'b0;
        for (int i = 0; i < cycles; i++) step(s, "reset", 1'b1, 7'b0001110, seen);
    endtask

    vec_t       tab [11];
    stim_t      s;
    logic [6:0] seen;
    int         n_busy, n_stall;

    initial begin
        for (int i = 0; i < 11; i++) tab[i] = '{s: idle(), exp: 7'b1110000};
        tab[1].s.memread = 1; tab[1].s.rt_rd = 8; tab[1].s.rs = 8; tab[1].exp = 7'b0010100;
        tab[2].s.memread = 1;                                       // ex_rt_rd=0 never stalls
        tab[3].s.memread = 1; tab[3].s.rt_rd = 8; tab[3].s.rt = 8; tab[3].s.rs = 3;
        tab[4].s.memread = 1; tab[4].s.rt_rd = 8; tab[4].s.rt = 8; tab[4].s.rs = 3;
        tab[4].s.uses_rt = 1; tab[4].exp = 7'b0010100;
        tab[5].s.bne = 1;                                           tab[5].exp = 7'b1111110;
        tab[6].s.branch = 1;
        tab[7].s.branch = 1; tab[7].s.zero = 1;                     tab[7].exp = 7'b1111110;
        tab[8].s.bne = 1; tab[8].s.zero = 1;
        tab[9].s.jump = 1; tab[9].s.muldiv = 1; tab[9].s.memread = 1;
        tab[9].s.rt_rd = 5; tab[9].s.rs = 5;                        tab[9].exp = 7'b1111110;
        tab[10].s.rt_rd = 8; tab[10].s.rs = 8;                      // no load in EX

        // Reset, then clean state after release.
        do_reset(3);
        step(idle(), "post_reset", 1'b1, 7'b1110000, seen);

        // Single load-use bubble sets stall_cnt to 1.
        do_reset(1);
        step(tab[1].s, "lu_single", 1'b1, tab[1].exp, seen);
        step(idle(), "lu_after", 1'b1, 7'b1110000, seen);
        #1 check("lu_stall_cnt", 32'(cnt0), 32'd1);

        for (int i = 0; i < 11; i++) step(tab[i].s, $sformatf("tab%0d", i), 1'b1, tab[i].exp, seen);
        step(idle(), "tab_end", 1'b1, 7'b1110000, seen);
        check("tab_jump_no_busy", 32'(busy0), 32'd0);

        // Mult/div with 4 cycles: operand held in EX while stalled.
        do_reset(1);
        s = idle(); s.muldiv = 1;
        n_busy = 0; n_stall = 0;
        for (int i = 0; i < 5; i++) begin
            step(s, "md", 1'b0, '0, seen);
            n_busy  += int'(seen[0]);
            n_stall += int'(!seen[6]);
            if (i == 4) check("md_release", 32'(seen), 32'(7'b1110001));
        end
        check("md_busy_cycles", 32'(n_busy), 32'd4);
        check("md_stall_cycles", 32'(n_stall), 32'd4);
        step(idle(), "md_after", 1'b1, 7'b1110000, seen);
        #1 check("md_stall_cnt", 32'(cnt0), 32'd4);

        // Jump aborting an active busy period, then reset aborting one.
        s = idle(); s.muldiv = 1;
        step(s, "md_abort_det", 1'b1, 7'b0000010, seen);
        step(idle(), "md_abort_busy", 1'b1, 7'b0000011, seen);
        s = idle(); s.jump = 1;
        step(s, "md_abort_jump", 1'b1, 7'b1111111, seen);
        step(idle(), "md_abort_run", 1'b1, 7'b1110000, seen);
        s = idle(); s.muldiv = 1;
        step(s, "md_rst_det", 1'b0, '0, seen);
        do_reset(1);
        step(idle(), "md_rst_run", 1'b1, 7'b1110000, seen);

        // Saturation of the 4-bit counter.
        do_reset(1);
        for (int i = 0; i < 20; i++) step(tab[1].s, "sat", 1'b0, '0, seen);
        #1 check("sat_stall_cnt", 32'(cnt0), 32'd15);

        // Random traffic against the model.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.rst     = ($urandom_range(63) != 0);
            s.rs      = 5'($urandom_range(3));
            s.rt      = 5'($urandom_range(3));
            s.uses_rt = 1'($urandom_range(1));
            s.memread = ($urandom_range(2) == 0);
            s.rt_rd   = 5'($urandom_range(3));
            s.muldiv  = ($urandom_range(7) == 0);
            s.branch  = ($urandom_range(9) == 0);
            s.bne     = ($urandom_range(9) == 0);
            s.zero    = 1'($urandom_range(1));
            s.jump    = ($urandom_range(15) == 0);
            step(s, "rand", 1'b0, '0, seen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It sits beside the IF/ID, ID/EX and EX/MEM registers. It generates their write-enable and flush controls, and the PC write-enable, from three conditions: a taken branch or jump resolved in MEM, a load-use dependency, and a multi-cycle mult/div occupying EX. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MULDIV_CYCLES, 32, number of busy cycles a mult/div holds EX (≥1)
- CNT_W, 6, width of the mult/div down-counter (must hold MULDIV_CYCLES-1)
- PERF_W, 16, width of the stall performance counter

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-low
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_MemRead  in  1  ID/EX MemRead (instruction in EX is a load)
- ex_rt_rd  in  5  destination register of instruction in EX
- ex_muldiv  in  1  instruction in EX is mult/multu/div/divu
- mem_branch  in  1  EX/MEM branch (beq)
- mem_bne  in  1  EX/MEM bne
- mem_zero  in  1  EX/MEM ALU zero flag
- mem_jump  in  1  EX/MEM jump
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- idex_write  out  1  ID/EX load enable
- ifid_flush  out  1  IF/ID loads a bubble
- idex_flush  out  1  ID/EX loads a bubble (all controls 0)
- exmem_flush  out  1  EX/MEM loads a bubble
- muldiv_busy  out  1  FSM in MD_BUSY
- stall_cnt  out  PERF_W  cycles with pc_write=0 since reset, saturating

## Operation
- Derived signals:
  - mem_taken = (mem_branch & mem_zero) | (mem_bne & ~mem_zero) | mem_jump.
  - load_use = ex_MemRead & (ex_rt_rd≠0) & ((ex_rt_rd==id_rs) | (id_uses_rt & ex_rt_rd==id_rt)).
- FSM states: RUN, MD_BUSY. Registers: state, md_cnt[CNT_W], stall_cnt.
- Control outputs are combinational (Mealy) from state, md_cnt and inputs. Default values: all writes 1, all flushes 0.
- Priority 1, mem_taken (either state):
  - ifid_flush = idex_flush = exmem_flush = 1; pc_write = 1.
  - Next state is RUN. A mult/div in EX is wrong-path and discarded; no busy period starts.
- Priority 2, RUN & ex_muldiv:
  - pc_write = ifid_write = idex_write = 0; exmem_flush = 1.
  - md_cnt ← MULDIV_CYCLES-1; next state MD_BUSY.
- Priority 3, RUN & load_use:
  - pc_write = ifid_write = 0; idex_flush = 1.
  - Exactly one bubble; the FSM stays in RUN.
- MD_BUSY, md_cnt≠0: same stall outputs as priority 2; md_cnt decrements.
- MD_BUSY, md_cnt==0: release cycle. All writes 1, all flushes 0; next state RUN.
  - In the release cycle, load_use is ignored (no load can be in EX).
  - ex_muldiv is not re-evaluated until the next RUN cycle.
- stall_cnt increments each cycle pc_write=0 and holds at all-ones.
- muldiv_busy = (state==MD_BUSY).

## Timing
- Reset: on posedge with rst=0, state ← RUN, md_cnt ← 0, stall_cnt ← 0.
- While rst=0:
  - pc_write = ifid_write = idex_write = 0.
  - ifid_flush = idex_flush = exmem_flush = 1.
  - muldiv_busy = 0.
- A reset asserted during MD_BUSY aborts the busy period immediately.
- Zero-latency decode: control outputs respond in the same cycle as their inputs.
- Mult/div latency: EX occupancy = MULDIV_CYCLES+1 cycles (detect cycle plus MULDIV_CYCLES MD_BUSY cycles). The stall window is MULDIV_CYCLES+1 minus the release cycle = MULDIV_CYCLES cycles with pc_write=0.
- MULDIV_CYCLES=1: one MD_BUSY cycle, which is also the release cycle.
- mem_taken in the same cycle as ex_muldiv or load_use: flush wins, and no stall is counted.
- mem_taken during MD_BUSY (EX/MEM normally holds a bubble): abort to RUN and flush. md_cnt is don't-care.
- load_use with ex_rt_rd=0 never stalls.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release. Required: flushes=1 and writes=0 during reset; after release stall_cnt=0, muldiv_busy=0, all writes=1.
- Load-use: ex_MemRead=1, ex_rt_rd=8, id_rs=8 for one cycle. Required: pc_write=0, ifid_write=0, idex_flush=1 for exactly 1 cycle; stall_cnt=1.
- Negative load-use cases: same stimulus with ex_rt_rd=0; then id_rt=8 with id_uses_rt=0. Required: no stall in either case.
- Branch resolution: mem_bne=1, mem_zero=0. Required: all three flushes=1 with pc_write=1. Also mem_branch=1, mem_zero=0: no flush.
- Mult/div with MULDIV_CYCLES=4: ex_muldiv=1 in RUN. Required: muldiv_busy=1 for 4 cycles; pc_write=0 for 4 cycles starting at detect; release cycle has all writes=1; stall_cnt=4.
- Priority and saturation:
  - mem_jump=1 together with ex_muldiv=1 and load_use: flush only, muldiv_busy stays 0.
  - PERF_W=4 with 20 stall cycles: stall_cnt holds at 15.
